ps2_host_rx: RTL and testbench

PS2_HOST_RX -- requirements
Module: ps2_host_rx

---
 rtl/ps2_host_rx.sv | 165 ++++++++++++++++
 tb/tb_ps2_host_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_rx.sv
// PS/2 host-side receiver: synchronizes and deglitches the device clock, then
// deserializes 11-bit frames (start, 8 data LSB first, odd parity, stop).
`timescale 1ns/1ps
module ps2_host_rx #(
  parameter int FILTER_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Handshake: valid/parity_err/frame_err are single-cycle strobes with no
  // ready; data is held stable between valid strobes.
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic            ck_meta_q, ck_meta_d, ck_sync_q, ck_sync_d;
  logic            dt_meta_q, dt_meta_d, dt_sync_q, dt_sync_d;
  logic            filt_q, filt_d;
  logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
  logic            armed_q, armed_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            par_q, par_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            sample;
  logic            timeout;

  always_comb begin
    ck_meta_d  = ps2_clk;
    ck_sync_d  = ck_meta_q;
    dt_meta_d  = ps2_data;
    dt_sync_d  = dt_meta_q;
    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    if (ck_sync_q == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) begin
      filt_d     = ck_sync_q;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
    // Edges only count once the real bus has been observed high after reset.
    armed_d = armed_q | (filt_q & ck_sync_q);
  end

  assign sample  = armed_q & filt_q & ~filt_d;
  assign timeout = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (state_q == IDLE || sample) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    // Timeout takes priority over a coincident sample event.
    if (timeout) begin
      state_d  = IDLE;
      ferr_d   = 1'b1;
      to_cnt_d = '0;
    end else if (sample) begin
      case (state_q)
        IDLE: begin
          if (!dt_sync_q) begin
            state_d   = DATA;
            shift_d   = '0;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dt_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dt_sync_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dt_sync_q) begin
            ferr_d = 1'b1;
          end else if (!(^{shift_q, par_q})) begin
            perr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ck_meta_q  <= 1'b1;
      ck_sync_q  <= 1'b1;
      dt_meta_q  <= 1'b1;
      dt_sync_q  <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      armed_q    <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ck_meta_q  <= ck_meta_d;
      ck_sync_q  <= ck_sync_d;
      dt_meta_q  <= dt_meta_d;
      dt_sync_q  <= dt_sync_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      armed_q    <= armed_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_rx.sv
// Randomized frame-level bench for ps2_host_rx with a byte/outcome reference model.
`timescale 1ns/1ps
module tb_ps2_host_rx;

  localparam int FILT = 16;
  localparam int TOUT = 1000;
  localparam int HALF = 100;

  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;
  localparam logic [1:0] K_FERR  = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_fall = 0;
  int          multi_hot = 0;
  int          data_glitch = 0;
  logic [7:0]  prev_data = 8'h00;
  logic [7:0]  exp_data  = 8'h00;

  logic [9:0]  exp_q[$];
  int unsigned exp_ref[$];
  logic [9:0]  obs_q[$];
  int unsigned obs_cyc[$];

  ps2_host_rx #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .valid(valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  // monitor: record every result strobe and watch data stability
  always @(negedge clk) begin
    if (rst) begin
      prev_data = data;
    end else begin
      if (valid || parity_err || frame_err) begin
        if ((int'(valid) + int'(parity_err) + int'(frame_err)) > 1) multi_hot++;
        if (valid)           obs_q.push_back({K_VALID, data});
        else if (parity_err) obs_q.push_back({K_PERR, 8'h00});
        else                 obs_q.push_back({K_FERR, 8'h00});
        obs_cyc.push_back(cyc);
      end
      if (data !== prev_data && !valid) data_glitch++;
      prev_data = data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      if (i == glitch_bit) begin
        tick(30);
        ps2_clk = 1'b0;
        tick(10);
        ps2_clk = 1'b1;
        tick(HALF - 40);
      end else begin
        tick(HALF);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      tick(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  // reference model: outcome of a complete frame from its fields
  task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop,
                            input int glitch_bit);
    logic       par;
    logic [9:0] ev;
    int         ones;
    ones = $countones(b);
    par  = par_good ? ((ones % 2) == 0) : ((ones % 2) == 1);
    if (!stop)                      ev = {K_FERR, 8'h00};
    else if (((ones + int'(par)) % 2) == 0) ev = {K_PERR, 8'h00};
    else begin
      ev = {K_VALID, b};
      exp_data = b;
    end
    send_bits({stop, par, b, 1'b0}, 11, glitch_bit);
    exp_q.push_back(ev);
    exp_ref.push_back(last_fall);
  endtask

  // scoreboard: compare recorded strobes against the expected queue
  task automatic check_frame(input string tag);
    int unsigned d;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_event"}, obs_q.pop_front(), exp_q.pop_front());
      d = obs_cyc.pop_front() - exp_ref.pop_front();
      check({tag, "_latency_ok"}, (d >= FILT + 1 && d <= FILT + 4), 1);
    end
    obs_q.delete(); obs_cyc.delete(); exp_q.delete(); exp_ref.delete();
    check({tag, "_data"}, data, exp_data);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(5);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(50);

    // falling edge with data high in IDLE is not a start bit
    ps2_data = 1'b1;
    ps2_clk  = 1'b0;
    tick(HALF);
    check("idle_one_busy", busy, 1'b0);
    ps2_clk = 1'b1;
    tick(HALF);
    check_frame("idle_one");

    send_frame(8'h1C, 1'b1, 1'b1, -1);
    check_frame("good_1c");
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    check_frame("bad_parity_f0");
    send_frame(8'h1C, 1'b1, 1'b0, -1);
    check_frame("bad_stop_1c");

    // start + 4 data bits then clock stalls high
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5, -1);
    ps2_data = 1'b1;
    tick(TOUT / 2);
    check("timeout_busy_mid", busy, 1'b1);
    exp_q.push_back({K_FERR, 8'h00});
    exp_ref.push_back(last_fall + TOUT);
    tick(TOUT);
    check_frame("timeout");
    send_frame(8'h29, 1'b1, 1'b1, -1);
    check_frame("after_timeout_29");

    send_frame(8'hA7, 1'b1, 1'b1, 4);
    check_frame("glitch_a7");

    // reset mid-frame after the 5th data bit
    send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 6, -1);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick(3);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_data", data, 8'h00);
    exp_data = 8'h00;
    rst = 1'b0;
    tick(20);
    check("post_rst_events", obs_q.size(), 0);
    send_frame(8'h5A, 1'b1, 1'b1, -1);
    check_frame("after_rst_5a");

    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      int         kind;
      int         g;
      b    = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 3);
      g    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : -1;
      send_frame(b, kind != 2, kind != 3, g);
      check_frame("random");
    end

    check("one_hot_results", multi_hot, 0);
    check("data_only_on_valid", data_glitch, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
